// File: rtl/ntt_commutator.sv
// Two-lane stride commutator: re-pairs coefficients D = 2^LOG_DEPTH samples apart
// between NTT butterfly stages, with frame realignment and a registered bypass.
module ntt_commutator #(
    parameter int LOGQ      = 17,
    parameter int LOG_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_v,
    input  logic            in_sof,
    input  logic            mode,
    input  logic [LOGQ-1:0] in0,
    input  logic [LOGQ-1:0] in1,
    output logic            out_v,
    output logic [LOGQ-1:0] out0,
    output logic [LOGQ-1:0] out1
);

    localparam int D  = 1 << LOG_DEPTH;
    localparam int CW = LOG_DEPTH + 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic            mode_q, mode_d;
    logic            out_v_q, out_v_d;
    logic [LOGQ-1:0] out0_q, out0_d;
    logic [LOGQ-1:0] out1_q, out1_d;

    logic [LOGQ-1:0] dla_q [D];
    logic [LOGQ-1:0] dlb_q [D];

    logic [CW-1:0]   k;
    logic            em;
    logic            sel;
    logic            acc_c;
    logic            acc_b;
    logic [LOGQ-1:0] head_a;
    logic [LOGQ-1:0] head_b;
    logic [LOGQ-1:0] mux_a;

    always_comb begin
        em     = (in_v && in_sof) ? mode : mode_q;
        k      = in_sof ? '0 : cnt_q;
        sel    = k[LOG_DEPTH];
        head_a = dla_q[D-1];
        head_b = dlb_q[D-1];
        mux_a  = sel ? head_a : in0;
        acc_c  = in_v && !em;
        acc_b  = in_v && em;
    end

    always_comb begin
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        mode_d  = mode_q;
        out_v_d = 1'b0;
        out0_d  = out0_q;
        out1_d  = out1_q;

        if (in_v && in_sof) begin
            mode_d = mode;
        end

        if (acc_b) begin
            out0_d  = in0;
            out1_d  = in1;
            out_v_d = 1'b1;
            cnt_d   = '0;
            fill_d  = '0;
        end else if (acc_c) begin
            // counter width is LOG_DEPTH+1, so the increment wraps modulo 2D
            cnt_d   = k + CW'(1);
            fill_d  = (fill_q == CW'(D)) ? fill_q : fill_q + CW'(1);
            out_v_d = (fill_q == CW'(D));
            out0_d  = head_b;
            out1_d  = sel ? in0 : head_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
            out_v_q <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
            out_v_q <= out_v_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
        end
    end

    // delay lines advance only on commutate samples; bypass and stalls hold them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                dla_q[i] <= '0;
                dlb_q[i] <= '0;
            end
        end else if (acc_c) begin
            dla_q[0] <= in1;
            dlb_q[0] <= mux_a;
            for (int i = 1; i < D; i++) begin
                dla_q[i] <= dla_q[i-1];
                dlb_q[i] <= dlb_q[i-1];
            end
        end
    end

    assign out_v = out_v_q;
    assign out0  = out0_q;
    assign out1  = out1_q;

endmodule

// File: doc/ntt_commutator.md
# ntt_commutator

Parametrised two-lane stride commutator for the NTT ALU datapath. It sits between butterfly stages and re-pairs coefficients so that elements `DEPTH = 2^LOG_DEPTH` samples apart meet at the next butterfly. Its features:
- valid-qualified streaming, so stalls are tolerated;
- frame alignment via `in_sof`;
- a registered bypass mode.

With `LOG_DEPTH = 0` it performs the single-sample exchange used by earlier NTT stages.

## Interface
- `LOGQ`, 17, coefficient width in bits.
- `LOG_DEPTH`, 3, log2 of commutation distance D; legal range 0..10.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_v`  in  1  input sample valid; no backpressure, accepted whenever high.
- `in_sof`  in  1  start of frame, qualified by `in_v`.
- `mode`  in  1  0 = commutate, 1 = bypass; sampled only with `in_v && in_sof`.
- `in0`  in  LOGQ  lane 0 coefficient.
- `in1`  in  LOGQ  lane 1 coefficient.
- `out_v`  out  1  output valid, registered.
- `out0`  out  LOGQ  lane 0 result, registered.
- `out1`  out  LOGQ  lane 1 result, registered.

## Operation
- Accepted sample: a cycle with `in_v=1`. No state changes on cycles with `in_v=0`, except `out_v` clearing to 0.
- Effective mode `em`: `mode` if `in_v && in_sof`, else `mode_q`. `mode_q` loads `mode` on `in_v && in_sof`.
- Sample counter `cnt` is LOG_DEPTH+1 bits. Sample index `k` is 0 if `in_sof`, else `cnt`. After an accepted commutate sample, `cnt <= k+1`, wrapping modulo 2D.
- Switch select `sel = k[LOG_DEPTH]`.
- Delay line A (D entries) holds `in1`. Delay line B (D entries) holds `mux_a`. Both shift one entry per accepted commutate sample.
- Per accepted commutate sample n, where `b` is the `in1` value and `a` is the `in0` value:
  - `sel=0`: `mux_a = in0`, next `out1 = b[n-D]` (head of A).
  - `sel=1`: `mux_a = b[n-D]`, next `out1 = in0`.
  - Next `out0` = head of B, i.e. `mux_a[n-D]`.
- Fill counter `fill` counts accepted commutate samples, saturating at D.
  - Next `out_v` = 1 only if `fill == D` before this sample is accepted.
  - Samples 0..D-1 after reset or after bypass therefore produce no valid output.
- Resulting stream for continuous input: pairs `(a0,aD)…(aD-1,a2D-1)`, then `(b0,bD)…(bD-1,b2D-1)`, then `(a2D,a3D)…`, each pair on `(out0,out1)`.
- Bypass sample (`em=1`):
  - `out0 <= in0`, `out1 <= in1`, `out_v <= 1`.
  - `cnt <= 0`, `fill <= 0`; delay lines hold.
- `in_sof` mid-stream in commutate mode realigns `cnt` only. Delay contents and `fill` are kept, so a continuous multi-frame stream has no bubbles.

## Timing
- Reset values:
  - `out_v=0`, `out0=0`, `out1=0`;
  - `cnt=0`, `fill=0`, `mode_q=0` (commutate);
  - all delay-line entries 0.
- Reset has priority over `in_v` in the same cycle. Reset mid-frame discards all in-flight data; the next accepted sample is index 0.
- Output register latency is 1 cycle after acceptance. Data latency is D samples plus 1 cycle.
- Stalls (`in_v=0`) hold `out0`/`out1` at their last values with `out_v=0`.
- `in_sof` with `in_v=0` is ignored.
- `LOG_DEPTH=0`: `sel` alternates every sample; behaviour reduces to an exchange with D=1.

## Test plan
- Reset, then check outputs before any input:
  - `rst` held 2 cycles → `out_v=0`, `out0=out1=0`, `cnt=0`.
- D=4 continuous stream:
  - Stimulus: `in_sof` on n=0, `in0=n`, `in1=100+n`, n=0..19.
  - Required response: `out_v` first high one cycle after n=4.
  - Pairs (0,4),(1,5),(2,6),(3,7),(100,104)…(103,107),(8,12)…(11,15),(108,112)…
- D=4 same stream with `in_v` deasserted every third cycle → identical valid-output sequence; outputs hold while `out_v=0`.
- Bypass:
  - Stimulus: `in_sof=1`, `mode=1`, then 3 samples (5,6), (7,8), (9,10).
  - Required response: `out_v=1` one cycle after each, with outputs (5,6), (7,8), (9,10).
  - Then `in_sof`, `mode=0` → D non-valid samples before the first pair.
- Realignment: `in_sof` asserted at n=10 of a D=4 stream → `sel=0` for n=10..13, and no `out_v` gap.
- Reset mid-frame at n=6 (D=4), then restart → no valid output until 4 new samples are accepted; first pair is (0,4) of the new stream.
